pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter NSTAGES, default 2, number of in-flight stages after decode (stage 1 = X, stage NSTAGES = last before regfile write); legal range 2..6.
REQ-002 SHALL have parameter REG_AW, default 5, register-address width.
REQ-003 SHALL have parameter CNT_W, default 32, statistics counter width.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port dec_valid  input  1  decode stage holds a real instruction.
REQ-007 SHALL have ports dec_rs1, dec_rs2  input  REG_AW  source registers of decode instruction.
REQ-008 SHALL have ports dec_use_rs1, dec_use_rs2  input  1  source actually read.
REQ-009 SHALL have port dec_rd  input  REG_AW  destination register.
REQ-010 SHALL have port dec_we  input  1  instruction writes regfile.
REQ-011 SHALL have port dec_is_load  input  1  instruction is a load.
REQ-012 SHALL have port br_taken  input  1  stage-1 branch/jump resolved taken.
REQ-013 SHALL have port stall  output  1  hold PC and decode, insert bubble.
REQ-014 SHALL have port flush  output  1  kill fetch/decode instruction.
REQ-015 SHALL have ports fwd_a_sel, fwd_b_sel  output  $clog2(NSTAGES+1)  0 = regfile, k = result of stage k.
REQ-016 SHALL have ports stg_valid, stg_we  output  NSTAGES  per-stage valid and qualified write enable (bit k-1 = stage k).
REQ-017 SHALL have ports stall_cnt, flush_cnt  output  CNT_W  event counters (present only per REQ-031).

Function
REQ-018 SHALL keep per stage k a scoreboard entry {valid, we, is_load, rd}; stage k+1 loads stage k every cycle; stage NSTAGES entry retires.
REQ-019 Stage 1 SHALL load {dec_valid, dec_we, dec_is_load, dec_rd} when stall=0 and flush=0, else a bubble (valid=0, we=0).
REQ-020 flush SHALL equal br_taken AND stage-1 valid, combinationally; br_taken with stage-1 invalid SHALL be ignored.
REQ-021 fwd_a_sel SHALL be the smallest k with stage k valid, we=1, rd==dec_rs1, given dec_use_rs1=1 and dec_rs1!=0; otherwise 0; fwd_b_sel identical for rs2.
REQ-022 stall SHALL be 1 when dec_valid=1, flush=0, and either source's selected k is 1 with stage-1 is_load=1 (load-use); otherwise 0.
REQ-023 A load matched at stage k>=2 SHALL forward without stall.
REQ-024 During stall, fwd selects SHALL still reflect the current match; after one bubble the load sits at stage 2 and stall drops (exactly one stall cycle per load-use).
REQ-025 Flush and stall coincident: flush wins, stall=0.
REQ-026 Register 0 SHALL never match, forward, or stall.
REQ-027 stg_we[k-1] SHALL equal stage-k valid AND we.
REQ-028 All outputs SHALL settle combinationally from scoreboard and decode inputs; scoreboard latency 1 cycle per stage.

Reset
REQ-029 On reset=1 at a clock edge, all scoreboard entries SHALL clear (valid=0, we=0, is_load=0, rd=0) and counters SHALL clear; reset mid-stall SHALL drop stall next cycle.
REQ-030 While scoreboard is clear: stall=0, flush=0, fwd selects=0, stg_valid=0, stg_we=0.

Configuration
REQ-031 Macro HAZARD_STATS_EN defined: stall_cnt increments each cycle stall=1, flush_cnt each cycle flush=1, both saturate at all-ones; undefined: ports absent, no counter logic.

Structure
REQ-032 Shared package SHALL hold fwd-select encoding constants (FWD_REGFILE=0) and the scoreboard-entry struct type.
REQ-033 One sub-module, hazard_match, SHALL compute match/priority for one source operand, instantiated twice.

Verification
REQ-034 ADD x5 then ADD using rs1=x5 (NSTAGES=2) -> fwd_a_sel=1, stall=0.
REQ-035 LW x7 then ADD rs2=x7 -> stall=1 one cycle, stage-1 bubble, next cycle fwd_b_sel=2, stall=0.
REQ-036 ADD x3 at stage 2 and ADD x3 at stage 1, decode reads x3 -> fwd_a_sel=1 (youngest wins).
REQ-037 Decode reads x0 with stage-1 rd=0, we=1 -> fwd_a_sel=0, stall=0.
REQ-038 Load-use coincident with br_taken and stage-1 valid -> flush=1, stall=0, stage 1 bubble; with HAZARD_STATS_EN flush_cnt=1, stall_cnt=0.
REQ-039 Reset asserted during stall, NSTAGES=4 -> next cycle all outputs 0, counters 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the hazard controller: forward-select encoding and scoreboard entry.
// The rd field is sized for the widest supported register address (REG_AW <= 8).
package pipe_hazard_ctrl_pkg;
  localparam int FWD_REGFILE = 0;
  localparam int SB_RD_W     = 8;

  typedef logic [SB_RD_W-1:0] sb_rd_t;

  typedef struct packed {
    logic   valid;
    logic   we;
    logic   is_load;
    sb_rd_t rd;
  } sb_entry_t;
endpackage

// File: rtl/pipe_hazard_ctrl_match.sv
// Per-operand forwarding match: picks the youngest in-flight stage writing the source register.
module hazard_match
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int NSTAGES = 2,
  parameter int SEL_W   = $clog2(NSTAGES+1)
) (
  input  sb_entry_t [NSTAGES-1:0] sb_i,
  input  sb_rd_t                  src_i,
  input  logic                    use_i,
  output logic      [SEL_W-1:0]   sel_o
);
  // Scan oldest to youngest so the smallest matching stage number is written last.
  always_comb begin
    sel_o = SEL_W'(FWD_REGFILE);
    if (use_i && (src_i != '0)) begin
      for (int k = NSTAGES; k >= 1; k--) begin
        if (sb_i[k-1].valid && sb_i[k-1].we && (sb_i[k-1].rd == src_i))
          sel_o = SEL_W'(k);
      end
    end
  end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// In-order pipeline hazard controller: scoreboard shift, forwarding selects, load-use stall, flush.
// Define HAZARD_STATS_EN to add saturating stall/flush event counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int NSTAGES = 2,
  parameter int REG_AW  = 5,
  parameter int CNT_W   = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           dec_valid,
  input  logic [REG_AW-1:0]              dec_rs1,
  input  logic [REG_AW-1:0]              dec_rs2,
  input  logic                           dec_use_rs1,
  input  logic                           dec_use_rs2,
  input  logic [REG_AW-1:0]              dec_rd,
  input  logic                           dec_we,
  input  logic                           dec_is_load,
  input  logic                           br_taken,
  output logic                           stall,
  output logic                           flush,
  output logic [$clog2(NSTAGES+1)-1:0]   fwd_a_sel,
  output logic [$clog2(NSTAGES+1)-1:0]   fwd_b_sel,
  output logic [NSTAGES-1:0]             stg_valid,
  output logic [NSTAGES-1:0]             stg_we
`ifdef HAZARD_STATS_EN
  ,
  output logic [CNT_W-1:0]               stall_cnt,
  output logic [CNT_W-1:0]               flush_cnt
`endif
);
  localparam int SEL_W = $clog2(NSTAGES+1);

  sb_entry_t [NSTAGES-1:0] sb_q, sb_d;

  hazard_match #(.NSTAGES(NSTAGES), .SEL_W(SEL_W)) u_match_a (
    .sb_i(sb_q), .src_i(SB_RD_W'(dec_rs1)), .use_i(dec_use_rs1), .sel_o(fwd_a_sel)
  );

  hazard_match #(.NSTAGES(NSTAGES), .SEL_W(SEL_W)) u_match_b (
    .sb_i(sb_q), .src_i(SB_RD_W'(dec_rs2)), .use_i(dec_use_rs2), .sel_o(fwd_b_sel)
  );

  assign flush = br_taken & sb_q[0].valid;
  // A stage-1 match implies a valid writing entry, so only is_load needs checking.
  assign stall = dec_valid & ~flush & sb_q[0].is_load &
                 ((fwd_a_sel == SEL_W'(1)) | (fwd_b_sel == SEL_W'(1)));

  always_comb begin
    sb_d[0] = '0;
    if (!stall && !flush)
      sb_d[0] = '{valid: dec_valid, we: dec_we, is_load: dec_is_load, rd: SB_RD_W'(dec_rd)};
    for (int k = 1; k < NSTAGES; k++)
      sb_d[k] = sb_q[k-1];
  end

  always_ff @(posedge clk) begin
    if (reset) sb_q <= '0;
    else       sb_q <= sb_d;
  end

  always_comb begin
    for (int k = 0; k < NSTAGES; k++) begin
      stg_valid[k] = sb_q[k].valid;
      stg_we[k]    = sb_q[k].valid & sb_q[k].we;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush && !(&flush_cnt_q)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: NSTAGES=2 and NSTAGES=4 instances share one decode stream.
module tb_pipe_hazard_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic       dec_valid, dec_use_rs1, dec_use_rs2, dec_we, dec_is_load, br_taken;
  logic [4:0] dec_rs1, dec_rs2, dec_rd;

  logic       stall2, flush2, stall4, flush4;
  logic [1:0] fa2, fb2, sv2, sw2;
  logic [2:0] fa4, fb4;
  logic [3:0] sv4, sw4;
`ifdef HAZARD_STATS_EN
  logic [31:0] sc2, fc2, sc4, fc4;
`endif

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.NSTAGES(2)) u_dut2 (
    .clk(clk), .reset(reset), .dec_valid(dec_valid),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2),
    .dec_rd(dec_rd), .dec_we(dec_we), .dec_is_load(dec_is_load), .br_taken(br_taken),
    .stall(stall2), .flush(flush2), .fwd_a_sel(fa2), .fwd_b_sel(fb2),
    .stg_valid(sv2), .stg_we(sw2)
`ifdef HAZARD_STATS_EN
    , .stall_cnt(sc2), .flush_cnt(fc2)
`endif
  );

  pipe_hazard_ctrl #(.NSTAGES(4)) u_dut4 (
    .clk(clk), .reset(reset), .dec_valid(dec_valid),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2),
    .dec_rd(dec_rd), .dec_we(dec_we), .dec_is_load(dec_is_load), .br_taken(br_taken),
    .stall(stall4), .flush(flush4), .fwd_a_sel(fa4), .fwd_b_sel(fb4),
    .stg_valid(sv4), .stg_we(sw4)
`ifdef HAZARD_STATS_EN
    , .stall_cnt(sc4), .flush_cnt(fc4)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dec(input logic v, input logic [4:0] rs1, input logic u1,
                     input logic [4:0] rs2, input logic u2,
                     input logic [4:0] rd, input logic we, input logic ld);
    dec_valid = v; dec_rs1 = rs1; dec_use_rs1 = u1; dec_rs2 = rs2; dec_use_rs2 = u2;
    dec_rd = rd; dec_we = we; dec_is_load = ld;
    #1;
  endtask

  initial begin
    reset = 1'b1; br_taken = 1'b0;
    dec(0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_stall", {31'd0, stall2}, 0);
    chk("rst_flush", {31'd0, flush2}, 0);
    chk("rst_fa", {30'd0, fa2}, 0);
    chk("rst_sv2", {30'd0, sv2}, 0);
    chk("rst_sw4", {28'd0, sw4}, 0);
`ifdef HAZARD_STATS_EN
    chk("rst_sc2", sc2, 0);
    chk("rst_fc2", fc2, 0);
`endif

    // ADD x5
    dec(1, 1, 1, 2, 1, 5, 1, 0);
    chk("t1_fa", {30'd0, fa2}, 0);
    tick();
    // ADD x8 <- x5, x6
    dec(1, 5, 1, 6, 1, 8, 1, 0);
    chk("t2_fa", {30'd0, fa2}, 1);
    chk("t2_fb", {30'd0, fb2}, 0);
    chk("t2_stall", {31'd0, stall2}, 0);
    chk("t2_sv2", {30'd0, sv2}, 2'b01);
    chk("t2_sw4", {28'd0, sw4}, 4'b0001);
    tick();
    // ADD x3 <- x5, x8
    dec(1, 5, 1, 8, 1, 3, 1, 0);
    chk("t3_fa", {30'd0, fa2}, 2);
    chk("t3_fb", {30'd0, fb2}, 1);
    chk("t3_sv4", {28'd0, sv4}, 4'b0011);
    tick();
    // ADD x3 <- x5: retired in 2-stage, stage 3 in 4-stage
    dec(1, 5, 1, 0, 0, 3, 1, 0);
    chk("t4_fa2", {30'd0, fa2}, 0);
    chk("t4_fa4", {29'd0, fa4}, 3);
    tick();
    // x3 at stages 1 and 2: youngest wins; this inst writes x0
    dec(1, 3, 1, 0, 1, 0, 1, 0);
    chk("t5_fa_young", {30'd0, fa2}, 1);
    chk("t5_fb_x0", {30'd0, fb2}, 0);
    tick();
    // reads x0 with stage-1 rd=0 we=1; this inst is LW x7
    dec(1, 0, 1, 0, 0, 7, 1, 1);
    chk("t6_fa_x0", {30'd0, fa2}, 0);
    chk("t6_stall", {31'd0, stall2}, 0);
    chk("t6_sw2", {30'd0, sw2}, 2'b11);
    tick();
    // load-use on rs2
    dec(1, 0, 0, 7, 1, 9, 1, 0);
    chk("t7_stall", {31'd0, stall2}, 1);
    chk("t7_fb", {30'd0, fb2}, 1);
    chk("t7_stall4", {31'd0, stall4}, 1);
    tick();
    chk("t8_stall", {31'd0, stall2}, 0);
    chk("t8_fb", {30'd0, fb2}, 2);
    chk("t8_sv2", {30'd0, sv2}, 2'b10);
    chk("t8_fb4", {29'd0, fb4}, 2);
    tick();
    // LW x7 <- x9
    dec(1, 9, 1, 0, 0, 7, 1, 1);
    chk("t9_fa", {30'd0, fa2}, 1);
    chk("t9_stall", {31'd0, stall2}, 0);
    tick();
    // load-use coincident with taken branch
    br_taken = 1'b1;
    dec(1, 0, 0, 7, 1, 10, 1, 0);
    chk("t10_flush", {31'd0, flush2}, 1);
    chk("t10_stall", {31'd0, stall2}, 0);
    chk("t10_fb", {30'd0, fb2}, 1);
    tick();
    // stage 1 is a bubble: branch must be ignored
    dec(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t11_flush_ign", {31'd0, flush2}, 0);
    chk("t11_sv2", {30'd0, sv2}, 2'b10);
    chk("t11_stall", {31'd0, stall2}, 0);
`ifdef HAZARD_STATS_EN
    chk("t11_sc2", sc2, 1);
    chk("t11_fc2", fc2, 1);
`endif
    br_taken = 1'b0;
    dec(1, 0, 0, 0, 0, 7, 1, 1);
    tick();
    dec(1, 7, 1, 0, 0, 4, 1, 0);
    chk("t13_stall4", {31'd0, stall4}, 1);
    reset = 1'b1;
    tick();
    chk("rst2_stall4", {31'd0, stall4}, 0);
    chk("rst2_flush4", {31'd0, flush4}, 0);
    chk("rst2_fa4", {29'd0, fa4}, 0);
    chk("rst2_fb4", {29'd0, fb4}, 0);
    chk("rst2_sv4", {28'd0, sv4}, 0);
    chk("rst2_sw4", {28'd0, sw4}, 0);
`ifdef HAZARD_STATS_EN
    chk("rst2_sc4", sc4, 0);
    chk("rst2_fc4", fc4, 0);
`endif
    reset = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
